// File: rtl/rv32_m_lsu_sequencer.sv
// rtl/rv32_m_lsu_sequencer.sv - LSU load/store sequencer onto a 32-bit word memory port
// Splits misaligned accesses into two aligned beats and merges/extends the read data.
module rv32_m_lsu_sequencer #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] r0_q;
  logic [31:0] r1_q;
  logic        err_q;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] last;
    last = {1'b0, off} + size_of(sz);
    return last > 3'd4;
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (f3[1:0] == 2'b11) return 1'b1;
    if (we) return f3[2];
    return f3 == 3'b110;
  endfunction

  logic        req_err;
  logic        two_beat;
  logic [7:0]  base_mask;
  logic [7:0]  m8;
  logic [63:0] wd64;
  logic [63:0] rd64;
  logic [31:0] load_data;
  logic [31:0] word_addr;

  assign req_err   = illegal_f3(req_we_i, req_funct3_i) ||
                     (!ALLOW_MISALIGNED && crosses_word(req_addr_i[1:0], req_funct3_i[1:0]));
  assign two_beat  = crosses_word(addr_q[1:0], f3_q[1:0]);
  assign word_addr = {addr_q[31:2], 2'b00};
  assign m8        = base_mask << addr_q[1:0];
  assign wd64      = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign rd64      = {r1_q, r0_q} >> {addr_q[1:0], 3'b000};

  always_comb begin
    base_mask = 8'h0F;
    case (f3_q[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
  end

  // funct3[2] selects zero extension (LBU/LHU)
  always_comb begin
    load_data = rd64[31:0];
    case (f3_q[1:0])
      2'b00:   load_data = f3_q[2] ? {24'b0, rd64[7:0]}  : {{24{rd64[7]}}, rd64[7:0]};
      2'b01:   load_data = f3_q[2] ? {16'b0, rd64[15:0]} : {{16{rd64[15]}}, rd64[15:0]};
      default: load_data = rd64[31:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'b0;
    rsp_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = 32'b0;
    mem_be_o    = 4'b0;
    mem_wdata_o = 32'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = rst_ni;
        if (req_valid_i) state_d = req_err ? RESP : REQ0;
      end
      REQ0: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = word_addr;
        mem_be_o    = we_q ? m8[3:0] : 4'b0;
        mem_wdata_o = wd64[31:0];
        if (mem_gnt_i) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid_i) state_d = two_beat ? REQ1 : RESP;
      end
      REQ1: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = word_addr + 32'd4;
        mem_be_o    = we_q ? m8[7:4] : 4'b0;
        mem_wdata_o = wd64[63:32];
        if (mem_gnt_i) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid_i) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
        rsp_rdata_o = (we_q || err_q) ? 32'b0 : load_data;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      r0_q    <= 32'b0;
      r1_q    <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
      end
      if (state_q == WAIT0 && mem_rvalid_i) r0_q <= mem_rdata_i;
      if (state_q == WAIT1 && mem_rvalid_i) r1_q <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_rv32_m_lsu_sequencer.sv
// tb/tb_rv32_m_lsu_sequencer.sv - self-checking bench for rv32_m_lsu_sequencer
// Byte-level reference memory predicts load data, beats and latency.
module tb_rv32_m_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        na_req_valid, na_req_ready, na_req_we;
  logic [2:0]  na_req_funct3;
  logic [31:0] na_req_addr, na_req_wdata;
  logic        na_rsp_valid, na_rsp_err;
  logic [31:0] na_rsp_rdata;
  logic        na_mem_req;
  logic        na_mem_gnt = 1'b0;
  logic        na_mem_rvalid = 1'b0;
  logic [31:0] na_mem_rdata = 32'b0;
  logic [31:0] na_mem_addr, na_mem_wdata;
  logic [3:0]  na_mem_be;

  always #5 clk = ~clk;

  rv32_m_lsu_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  rv32_m_lsu_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_na (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(na_req_valid), .req_ready_o(na_req_ready), .req_we_i(na_req_we),
    .req_funct3_i(na_req_funct3), .req_addr_i(na_req_addr), .req_wdata_i(na_req_wdata),
    .rsp_valid_o(na_rsp_valid), .rsp_rdata_o(na_rsp_rdata), .rsp_err_o(na_rsp_err),
    .mem_req_o(na_mem_req), .mem_gnt_i(na_mem_gnt), .mem_addr_o(na_mem_addr),
    .mem_be_o(na_mem_be), .mem_wdata_o(na_mem_wdata),
    .mem_rvalid_i(na_mem_rvalid), .mem_rdata_i(na_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_words [logic [31:0]];
  logic [7:0]  ref_bytes [logic [31:0]];
  logic [31:0] beat_addr[$];
  logic [3:0]  beat_be[$];
  logic [31:0] beat_wd[$];
  int          stab_bad;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gw;
    logic        pre;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] w);
    return mem_words.exists(w) ? mem_words[w] : dflt(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] b);
    logic [31:0] w;
    if (ref_bytes.exists(b)) return ref_bytes[b];
    w = dflt({b[31:2], 2'b00});
    return w[8*b[1:0] +: 8];
  endfunction

  function automatic bit ref_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] w);
    mem_words[a] = w;
    for (int j = 0; j < 4; j++) ref_bytes[a + 32'(j)] = w[8*j +: 8];
  endtask

  // Memory responder: grants after gw waiting cycles, returns read data the next cycle.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gw,
                         output logic [31:0] rd, output logic er, output int cyc);
    logic        pend, in_beat, got;
    logic [31:0] pend_addr, w;
    int          wait_cnt;
    beat_addr.delete(); beat_be.delete(); beat_wd.delete();
    stab_bad = 0; pend = 0; in_beat = 0; got = 0; wait_cnt = 0; pend_addr = 0;
    rd = 0; er = 0; cyc = -1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; cyc = c; got = 1;
        break;
      end
      if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = mem_rd(pend_addr); pend = 0;
      end
      if (mem_req) begin
        if (!in_beat) begin
          in_beat = 1; wait_cnt = 0;
          beat_addr.push_back(mem_addr); beat_be.push_back(mem_be); beat_wd.push_back(mem_wdata);
        end else if (mem_addr !== beat_addr[$] || mem_be !== beat_be[$] || mem_wdata !== beat_wd[$]) begin
          stab_bad++;
        end
        if (wait_cnt == gw) begin
          mem_gnt = 1'b1; pend = 1; pend_addr = mem_addr; in_beat = 0;
          w = mem_rd(mem_addr);
          for (int j = 0; j < 4; j++) if (mem_be[j]) w[8*j +: 8] = mem_wdata[8*j +: 8];
          if (mem_be != 4'b0) mem_words[mem_addr] = w;
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("rsp_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_check(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gw,
                          output logic [31:0] rd, output logic er);
    int          n, off, nb, exp_cyc, cyc, idx;
    bit          legal;
    logic [31:0] exp_rd, ewa, ewd;
    logic [3:0]  ebe;
    legal = ref_legal(we, f3);
    n     = ref_size(f3);
    off   = int'(addr[1:0]);
    nb    = !legal ? 0 : ((off + n > 4) ? 2 : 1);
    exp_rd = 32'b0;
    if (legal && !we) begin
      for (int i = 0; i < n; i++) exp_rd[8*i +: 8] = ref_byte(addr + 32'(i));
      if (!f3[2] && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFFFFFF << (8*n));
    end
    exp_cyc = !legal ? 1 : (nb == 1 ? 3 + gw : 5 + 2*gw);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    run_txn(we, f3, addr, wdata, gw, rd, er, cyc);
    chk("rsp_err", 32'(er), 32'(!legal));
    chk("rsp_rdata", rd, exp_rd);
    chk("rsp_cycle", 32'(cyc), 32'(exp_cyc));
    chk("beat_count", 32'(beat_addr.size()), 32'(nb));
    chk("beat_stable", 32'(stab_bad), 32'd0);
    for (int k = 0; k < nb && k < beat_addr.size(); k++) begin
      ewa = {addr[31:2], 2'b00} + 32'(4*k);
      ebe = 4'b0; ewd = 32'b0;
      for (int j = 0; j < 4; j++) begin
        idx = 4*k + j - off;
        if (idx >= 0 && idx < 4) ewd[8*j +: 8] = wdata[8*idx +: 8];
        if (we && idx >= 0 && idx < n) ebe[j] = 1'b1;
      end
      chk("beat_addr", beat_addr[k], ewa);
      chk("beat_be", 32'(beat_be[k]), 32'(ebe));
      chk("beat_wdata", beat_wd[k], ewd);
    end
    if (legal && we)
      for (int i = 0; i < n; i++) ref_bytes[addr + 32'(i)] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [2:0]  f3;
    logic [31:0] addr;

    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b1, 32'h80FF1234, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b1, 32'h80FF1234, 32'h0, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 3'b001, 32'h103, 32'h0000ABCD, 0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h103, 32'h0, 0, 1'b0, 32'h0, 32'h0, 32'h0000ABCD, 1'b0};
    vecs[5]  = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 1'b1, 32'h11223344, 32'h55667788, 32'h77881122, 1'b0};
    vecs[6]  = '{1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 3'b100, 32'h100, 32'h12345678, 0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 3'b001, 32'h102, 32'h0, 5, 1'b1, 32'h80015678, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[9]  = '{1'b1, 3'b010, 32'h101, 32'hCAFEF00D, 3, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 32'h002, 32'h123456A5, 0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 3'b000, 32'h002, 32'h0, 2, 1'b0, 32'h0, 32'h0, 32'hFFFFFFA5, 1'b0};
    vecs[13] = '{1'b0, 3'b111, 32'h003, 32'h0, 0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1};

    rst_n = 1'b0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    na_req_valid = 0; na_req_we = 0; na_req_funct3 = 0; na_req_addr = 0; na_req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_be", 32'(mem_be), 32'd0);

    // Misalignment disallowed: immediate error with no memory beat
    for (int t = 0; t < 2; t++) begin
      na_req_valid = 1'b1; na_req_we = 1'b0;
      na_req_funct3 = (t == 0) ? 3'b010 : 3'b011;
      na_req_addr = (t == 0) ? 32'h2 : 32'h100;
      @(negedge clk);
      na_req_valid = 1'b0;
      chk("na_rsp_valid_c1", 32'(na_rsp_valid), 32'd1);
      chk("na_rsp_err", 32'(na_rsp_err), 32'd1);
      chk("na_rsp_rdata", na_rsp_rdata, 32'd0);
      chk("na_no_mem_req", 32'(na_mem_req), 32'd0);
      @(negedge clk);
      chk("na_back_idle", 32'(na_req_ready), 32'd1);
    end

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].pre) begin
        preset({vecs[i].addr[31:2], 2'b00}, vecs[i].w0);
        preset({vecs[i].addr[31:2], 2'b00} + 32'd4, vecs[i].w1);
      end
      do_check(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].gw, rd, er);
      chk("vec_rdata", rd, vecs[i].exp_rd);
      chk("vec_err", 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset while the second beat of a split load is outstanding
    preset(32'h200, 32'h11223344);
    preset(32'h204, 32'h55667788);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h201; req_wdata = 0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_seq_beat0", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rst_seq_beat1_addr", mem_addr, 32'h204);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wait1_ready", 32'(req_ready), 32'd0);
    chk("rst_wait1_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait1_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_rvalid_rsp", 32'(rsp_valid), 32'd0);
    chk("stray_rvalid_mem_req", 32'(mem_req), 32'd0);
    do_check(1'b0, 3'b010, 32'h200, 32'h0, 0, rd, er);
    chk("after_reset_lw", rd, 32'h11223344);

    for (int i = 0; i < 200; i++) begin
      f3 = 3'($urandom % 8);
      if ($urandom % 4 == 0) addr = 32'hFFFFFFF0 + 32'($urandom % 16);
      else                   addr = 32'h1000 + 32'($urandom % 32);
      do_check(1'($urandom % 2), f3, addr, $urandom, int'($urandom % 3), rd, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_m_lsu_sequencer.md
Name: rv32_m_lsu_sequencer

Overview:
- Sequences every load/store from the LSU onto the single 32-bit word-addressed data memory port.
- Splits misaligned halfword/word accesses into two aligned beats and merges the read data.
- Applies byte enables, applies sign/zero extension, and reports one response per request.
- Sits between the execute-stage LSU and the data RAM/bus; the LSU issues one request at a time.

Parameters:
- ALLOW_MISALIGNED, 1, 1: split misaligned accesses into two beats; 0: return an error with no memory beat.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  LSU request valid
- req_ready_o  out  1  sequencer can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32 load/store funct3
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores
- rsp_err_o  out  1  misaligned (when disallowed) or illegal funct3
- mem_req_o  out  1  memory beat request
- mem_gnt_i  in  1  beat accepted
- mem_addr_o  out  32  word-aligned address, bits [1:0] = 0
- mem_be_o  out  4  byte write enables; 0 for loads
- mem_wdata_o  out  32  lane-shifted write data
- mem_rvalid_i  in  1  beat completion, one per granted beat, in order
- mem_rdata_i  in  32  read word, valid with mem_rvalid_i

Behaviour:
- Reset (asynchronous, rst_ni low):
  - FSM returns to IDLE.
  - All outputs 0, except req_ready_o = 1 once reset is released.
  - Captured request and beat-0 data are cleared.
  - An in-flight beat is abandoned; a stray mem_rvalid_i seen in IDLE is ignored.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready_o = 1 only in IDLE.
  - On req_valid_i, capture we, funct3, addr, wdata.
  - Illegal funct3 (load 011/110/111, store 011/1xx), or misaligned with ALLOW_MISALIGNED = 0 → RESP with err = 1.
  - Otherwise → REQ0.
- Size and offset:
  - Size n = 1/2/4 from funct3[1:0]; off = addr[1:0].
  - Misaligned (two beats) when off + n > 4.
- Lane mask and write data:
  - m8 = ((1<<n)-1) << off, an 8-bit mask.
  - wd64 = {32'b0, wdata} << (8*off).
- REQ0:
  - mem_req_o = 1, mem_addr_o = {addr[31:2], 2'b00}.
  - mem_be_o = we ? m8[3:0] : 0; mem_wdata_o = wd64[31:0].
  - Outputs held stable until mem_gnt_i; on gnt → WAIT0.
- WAIT0:
  - On mem_rvalid_i, store mem_rdata_i as r0.
  - → REQ1 if two beats, else → RESP.
- REQ1:
  - mem_addr_o = {addr[31:2], 2'b00} + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - mem_be_o = we ? m8[7:4] : 0; mem_wdata_o = wd64[63:32].
  - On gnt → WAIT1.
- WAIT1: on mem_rvalid_i → RESP, keeping r1 = mem_rdata_i.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then → IDLE.
  - Load data: d = ({r1, r0} >> 8*off), truncated to n bytes.
  - funct3[2] = 1 zero-extends d; otherwise sign-extends from its top bit.
  - Stores and errors return rdata = 0.
- Latency, aligned access with gnt in the request cycle and rvalid one cycle later:
  - Request accepted at cycle 0; mem_req at 1; rvalid at 2; rsp_valid at 3.
  - A misaligned access adds 2 cycles.
  - Errors respond at cycle 1.
- Simultaneous events:
  - mem_rvalid_i in REQ0/REQ1 (beat not granted) is a protocol violation; the block ignores it.
  - A new request is never accepted in the same cycle as rsp_valid_o.
- The response has no backpressure; the LSU must take it when rsp_valid_o pulses.

Test Plan:
- Aligned LW at 0x100, mem returns 0xDEADBEEF, gnt immediate → single beat at 0x100 with be = 0; rsp at cycle 3 with rdata = 0xDEADBEEF, err = 0.
- LB at 0x103 with word 0x80FF1234 → rdata = 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH 0xABCD at 0x103 → beat0: addr 0x100, be = 1000, wdata[31:24] = 0xCD; beat1: addr 0x104, be = 0001, wdata[7:0] = 0xAB; one rsp, err = 0.
- LW at 0xFFFFFFFE, words 0x1122_3344 then 0x5566_7788 → beats at 0xFFFFFFFC and 0x00000000; rdata = 0x77881122.
- ALLOW_MISALIGNED = 0, LW at 0x2 → no mem_req_o; rsp_valid_o at cycle 1 with err = 1. Load funct3 = 011 → err = 1.
- mem_gnt_i held low for 5 cycles → addr/be/wdata stable throughout. Reset asserted in WAIT1 → outputs 0 immediately; subsequent rvalid ignored; next LW completes correctly.
